change_dispenser: RTL
=====================

# change_dispenser

Change payout driver for the vending machine: the outbound counterpart of the coin1/coin2/coin5/coin10 acceptance path. When a transaction completes, it takes the 7-bit change amount from the calculation block and emits a greedy sequence of fixed-width coin-eject pulses (10, 5, 2, 1) to the payout mechanism. It signals busy/done back to the mode controller. An optional per-denomination inventory can be compiled in, so that empty coin tubes are skipped and a shortfall is reported.

## Interface
- PULSE_CYCLES, 4: clk cycles each eject pulse is held high (≥1)
- GAP_CYCLES, 4: minimum low cycles after each pulse (≥1)
- STOCK_INIT, 15: coins per tube after reset/refill (1..15, inventory build only)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- change  in  7  amount to pay out, 0..127, latched on accepted start
- refill  in  1  single-cycle pulse; restores all tubes to STOCK_INIT
- coin10_out, coin5_out, coin2_out, coin1_out  out  1 each  eject pulses, at most one high at a time
- busy  out  1  high from the cycle after accepted start through DONE
- done  out  1  one-cycle completion strobe
- short  out  1  payout ended with remaining > 0; valid with done, held until next accepted start
- remaining  out  7  amount still owed

## Operation
- States: IDLE, SELECT, PULSE, GAP, DONE.
- IDLE: start=1 → latch change into remaining, clear short, go to SELECT. start is ignored in every other state.
- SELECT (1 cycle):
  - remaining==0 → DONE.
  - Otherwise pick the largest denomination d ≤ remaining (with inventory: d must also have stock > 0), subtract d from remaining, decrement that stock, and go to PULSE.
  - No eligible d (inventory only) → set short, go to DONE.
- PULSE: the selected coinX_out is high for exactly PULSE_CYCLES cycles, then go to GAP.
- GAP: all coin outputs low for GAP_CYCLES cycles, then go to SELECT.
- DONE: done=1 for one cycle, then go to IDLE.
- Width rules:
  - remaining never underflows, because the selection guarantees d ≤ remaining.
  - Stock counters are 4-bit and never wrap below 0.
- refill takes effect in any state. If it coincides with a decrement in SELECT, refill wins and the tube holds STOCK_INIT.
- Reset (async, any time, including mid-pulse):
  - State → IDLE.
  - All coin outputs, busy, done and short → 0.
  - remaining → 0.
  - Stocks → STOCK_INIT.
  - A pulse in progress is truncated immediately.

## Timing
- Start accepted at edge k: busy=1 and state=SELECT during cycle k+1.
- Each coin costs 1+PULSE_CYCLES+GAP_CYCLES cycles (SELECT+PULSE+GAP).
- For N coins, done is high in cycle k+2+N·(1+PULSE_CYCLES+GAP_CYCLES). busy drops in the following cycle.
- remaining updates on the SELECT→PULSE edge, so it already shows the post-coin value during PULSE.
- All outputs are registered; no combinational path from inputs to outputs.
- A start in the same cycle as done (state DONE) is ignored. The earliest re-accept is the first IDLE cycle.

## Configuration
- CHANGE_INVENTORY_EN defined:
  - Four 4-bit stock counters are instantiated.
  - Selection skips empty tubes.
  - short reports the shortfall.
  - refill is active.
- Not defined:
  - No counters; supply is unlimited.
  - Payout always completes with remaining=0.
  - short is tied 0 and refill is ignored; both ports remain present.

## Test plan
- Reset defaults: assert rst mid-PULSE of a change=10 payout → coin10_out falls without waiting for a clock. All outputs are 0 and state is IDLE after release.
- change=0, start at edge k (PULSE=GAP=4) → no coin pulses; done at k+2; short=0.
- change=17 → exactly three pulses, in order 10, 5, 2, each 4 cycles wide with 4-cycle gaps. done at k+2+3·9=k+29. remaining shows 7, 2, 0.
- change=99 → 9×coin10, 1×coin5, 2×coin2, 0×coin1 (12 pulses). No two outputs high simultaneously. A start pulsed mid-payout is ignored.
- CHANGE_INVENTORY_EN, STOCK_INIT=1, change=25 → pulses 10, 5, 2, 1, then done with short=1 and remaining=7. refill then change=3 → pulses 2, 1; short=0.
- CHANGE_INVENTORY_EN, refill coincident with the SELECT that takes the last coin10 → that tube reads STOCK_INIT afterwards. A following change=10 pays a single coin10.

Source files
------------

// File: rtl/change_dispenser.sv
//----------------------------------------------------------------------------
// Module      : change_dispenser
// Description : Greedy change payout driver. Latches a 7-bit change amount
//               and emits fixed-width eject pulses for 10/5/2/1 coins with a
//               guaranteed low gap after each, reporting busy/done.
//               Optional per-tube inventory (macro CHANGE_INVENTORY_EN) skips
//               empty tubes and reports a shortfall on `short`.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module change_dispenser #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int STOCK_INIT   = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] change,
  input  logic       refill,
  output logic       coin10_out,
  output logic       coin5_out,
  output logic       coin2_out,
  output logic       coin1_out,
  output logic       busy,
  output logic       done,
  output logic       short,
  output logic [6:0] remaining
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_PULSE  = 3'd2,
    S_GAP    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] C_PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [6:0]       r_remaining;
  logic [3:0]       r_coin;      // {10, 5, 2, 1}
  logic             r_busy;
  logic             r_done;
  logic [3:0]       w_avail;     // tube has at least one coin, {10, 5, 2, 1}
  logic [3:0]       w_pick;      // one-hot chosen denomination
  logic [6:0]       w_pick_val;  // value of the chosen denomination

  // Largest eligible denomination not exceeding the amount still owed
  always_comb begin
    w_pick     = 4'b0000;
    w_pick_val = 7'd0;
    if (r_remaining >= 7'd10 && w_avail[3]) begin
      w_pick     = 4'b1000;
      w_pick_val = 7'd10;
    end else if (r_remaining >= 7'd5 && w_avail[2]) begin
      w_pick     = 4'b0100;
      w_pick_val = 7'd5;
    end else if (r_remaining >= 7'd2 && w_avail[1]) begin
      w_pick     = 4'b0010;
      w_pick_val = 7'd2;
    end else if (r_remaining >= 7'd1 && w_avail[0]) begin
      w_pick     = 4'b0001;
      w_pick_val = 7'd1;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_SELECT;
      S_SELECT: w_next = (w_pick == 4'b0000) ? S_DONE : S_PULSE;
      S_PULSE:  if (r_cnt == C_PULSE_LAST) w_next = S_GAP;
      S_GAP:    if (r_cnt == C_GAP_LAST) w_next = S_SELECT;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Dwell counter for PULSE/GAP; restarts on every state change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_next != r_state || !(r_state == S_PULSE || r_state == S_GAP)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Registered outputs decoded from the upcoming state so they align with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_coin <= 4'b0000;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= (w_next == S_DONE);
      if (w_next == S_PULSE)
        r_coin <= (r_state == S_SELECT) ? w_pick : r_coin;
      else
        r_coin <= 4'b0000;
    end
  end

  // Amount owed: loaded on accepted start, reduced as each coin is chosen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_remaining <= 7'd0;
    end else if (r_state == S_IDLE && start) begin
      r_remaining <= change;
    end else if (r_state == S_SELECT) begin
      r_remaining <= r_remaining - w_pick_val;
    end
  end

`ifdef CHANGE_INVENTORY_EN
  localparam logic [3:0] C_STOCK_INIT = 4'(STOCK_INIT);

  logic r_short;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_tube
      logic [3:0] r_stock;

      // Tube stock: refill overrides a same-cycle decrement
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_stock <= C_STOCK_INIT;
        end else if (refill) begin
          r_stock <= C_STOCK_INIT;
        end else if (r_state == S_SELECT && w_pick[g] && r_stock != 4'd0) begin
          r_stock <= r_stock - 4'd1;
        end
      end

      assign w_avail[g] = (r_stock != 4'd0);
    end
  endgenerate

  // Shortfall flag: cleared on accepted start, set when nothing can be paid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_short <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_short <= 1'b0;
    end else if (r_state == S_SELECT && r_remaining != 7'd0 && w_pick == 4'b0000) begin
      r_short <= 1'b1;
    end
  end

  assign short = r_short;
`else
  // Unlimited supply: refill and stock size have no effect
  logic w_unused_ok;
  assign w_unused_ok = refill | (STOCK_INIT == 0);
  assign w_avail     = 4'b1111;
  assign short       = 1'b0;
`endif

  assign {coin10_out, coin5_out, coin2_out, coin1_out} = r_coin;
  assign busy      = r_busy;
  assign done      = r_done;
  assign remaining = r_remaining;

endmodule

`default_nettype wire
